// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the fetch stage.
//   XLEN     - datapath width (32)
//   CNT_W    - stall/flush counter width (16)
//   NOP      - instruction injected as a bubble (32'h0000_0000)
//   RESET_PC - fetch address after reset (32'h0000_0000)
//   ifid_t   - IF/ID pipeline register payload
package mips_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 16;

    localparam logic [XLEN-1:0] NOP      = 32'h0000_0000;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] ir;
        logic [XLEN-1:0] pc4;
        logic            valid;
    } ifid_t;

    // Sequential fetch address; wraps modulo 2^32 with no carry out.
    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones.
// Ports:
//   clk   - clock
//   clear - synchronous clear, wins over inc
//   inc   - increment request for this edge
//   count - current count (registered)
module sat_counter
    import mips_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up, holding once every bit is set.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with PC register, IF/ID register and a
// sticky halt flag. Optional stall/flush counters are built only when the
// STALL_COUNT_EN macro is defined; otherwise Lock_Cnt/Flush_Cnt are tied to 0.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   LOCK_IF, LOCK_ID    - independent load-use holds for PC and IF/ID
//   Redirect/_PC        - taken branch/jump from EX and its target
//   Halt_ID             - halt decoded in ID
//   Instr_IF            - instruction memory read data for PC_IF
//   PC_IF               - fetch address (instruction memory address)
//   IR_ID/PC4_ID/Valid_ID - IF/ID register contents
//   Halted              - fetch frozen until reset
//   Lock_Cnt/Flush_Cnt  - LOCK_IF cycle and flush counters
module if_stage
    import mips_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             LOCK_IF,
    input  logic             LOCK_ID,
    input  logic             Redirect,
    input  logic [XLEN-1:0]  Redirect_PC,
    input  logic             Halt_ID,
    input  logic [XLEN-1:0]  Instr_IF,
    output logic [XLEN-1:0]  PC_IF,
    output logic [XLEN-1:0]  IR_ID,
    output logic [XLEN-1:0]  PC4_ID,
    output logic             Valid_ID,
    output logic             Halted,
    output logic [CNT_W-1:0] Lock_Cnt,
    output logic [CNT_W-1:0] Flush_Cnt
);

    logic [XLEN-1:0] pc_q;
    ifid_t           ifid_q;
    logic            halted_q;
    logic            halt_take;

    localparam ifid_t IFID_BUBBLE = '{ir: NOP, pc4: '0, valid: 1'b0};

    // A halt only counts when it belongs to a real instruction that is not
    // being squashed by a redirect in the same cycle.
    assign halt_take = Halt_ID && ifid_q.valid && !Redirect;

    // PC, IF/ID and halt flag; once halted everything freezes until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            ifid_q   <= IFID_BUBBLE;
            halted_q <= 1'b0;
        end else if (!halted_q) begin
            if (Redirect) begin
                pc_q <= Redirect_PC;
            end else if (!LOCK_IF) begin
                pc_q <= pc_plus4(pc_q);
            end

            // Redirect outranks LOCK_ID so the bubble is never held.
            if (Redirect) begin
                ifid_q <= IFID_BUBBLE;
            end else if (!LOCK_ID) begin
                ifid_q <= '{ir: Instr_IF, pc4: pc_plus4(pc_q), valid: 1'b1};
            end

            if (halt_take) begin
                halted_q <= 1'b1;
            end
        end
    end

    assign PC_IF    = pc_q;
    assign IR_ID    = ifid_q.ir;
    assign PC4_ID   = ifid_q.pc4;
    assign Valid_ID = ifid_q.valid;
    assign Halted   = halted_q;

`ifdef STALL_COUNT_EN
    logic lock_inc;
    logic flush_inc;

    // Events are counted only while fetch is live; redirect masks a lock.
    assign lock_inc  = LOCK_IF && !Redirect && !halted_q;
    assign flush_inc = Redirect && !halted_q;

    sat_counter #(.W(CNT_W)) u_lock_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (lock_inc),
        .count (Lock_Cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (flush_inc),
        .count (Flush_Cnt)
    );
`else
    assign Lock_Cnt  = '0;
    assign Flush_Cnt = '0;
`endif

endmodule
